// File: rtl/peri_charlieplex_keypad_if.sv
// Wishbone B4 slave bundle for the charlieplex keypad register window.
// master drives we/adr/dat_i/stb; slave returns dat_o/ack.
interface peri_charlieplex_keypad_if;
   logic       wb_we_i;
   logic [3:0] wb_adr_i;
   logic [7:0] wb_dat_i;
   logic       wb_stb_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;

   modport master (
      output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/peri_charlieplex_keypad.sv
// Charlieplexed 7-pin keypad scanner with 2-scan debounce and irq.
// Ports: clk_i/rst_ni, wb (slave bus), charlieplex_i/_o/_out_en_o, irq_o.
module peri_charlieplex_keypad #(
   parameter int SettleTicks = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   peri_charlieplex_keypad_if.slave      wb,
   input  logic [6:0]                    charlieplex_i,
   output logic [6:0]                    charlieplex_o,
   output logic [6:0]                    charlieplex_out_en_o,
   output logic                          irq_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;
   localparam logic [7:0] CntMax = 8'(SettleTicks - 1);

   logic [0:0] state;
   logic [2:0] pin;
   logic [7:0] cnt;
   logic [6:0] sync1;
   logic [6:0] sync2;
   logic [7:0] raw [7];
   logic [7:0] key [7];
   logic       changed;
   logic       enable;
   logic       irq_en;
   logic       ack;
   logic [7:0] dat;

   logic [7:0] s;
   logic [7:0] row_d;
   logic [7:0] rdata;
   logic       sample;
   logic       req;
   logic       wr;
   logic       set_chg;
   logic       clr_chg;

   // Keys only update where this scan agrees with the previous one.
   always_comb begin
      s       = {1'b0, ~sync2} & ~(8'h01 << pin);
      sample  = (state == DRIVE) & enable & (cnt == CntMax);
      row_d   = (s & ~(s ^ raw[pin])) | (key[pin] & (s ^ raw[pin]));
      set_chg = sample & (row_d != key[pin]);
   end

   always_comb begin
      req     = wb.wb_stb_i & ~ack;
      wr      = req & wb.wb_we_i;
      clr_chg = wr & (wb.wb_adr_i == 4'd7) & wb.wb_dat_i[0];
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         (wb.wb_adr_i < 4'd7):
            rdata = key[wb.wb_adr_i[2:0]];
         (wb.wb_adr_i == 4'd7):
            rdata = {6'b0, state == DRIVE, changed};
         (wb.wb_adr_i == 4'd8):
            rdata = {6'b0, irq_en, enable};
         default:
            rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= charlieplex_i;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         pin     <= '0;
         cnt     <= '0;
         changed <= 1'b0;
         enable  <= 1'b1;
         irq_en  <= 1'b0;
         ack     <= 1'b0;
         dat     <= '0;
         for (int i = 0; i < 7; i++) begin
            raw[i] <= '0;
            key[i] <= '0;
         end
      end else begin
         ack <= req;
         dat <= req ? rdata : 8'h00;
         if (wr && wb.wb_adr_i == 4'd8) begin
            enable <= wb.wb_dat_i[0];
            irq_en <= wb.wb_dat_i[1];
         end
         // A new change beats a same-cycle clear.
         if (set_chg)
            changed <= 1'b1;
         else if (clr_chg)
            changed <= 1'b0;
         if (sample) begin
            raw[pin] <= s;
            key[pin] <= row_d;
         end
         if (state == IDLE) begin
            pin <= '0;
            cnt <= '0;
            if (enable)
               state <= DRIVE;
         end else if (!enable) begin
            // Abandon the slot; rescans restart at pin 0.
            state <= IDLE;
            pin   <= '0;
            cnt   <= '0;
         end else if (cnt == CntMax) begin
            cnt <= '0;
            pin <= (pin == 3'd6) ? 3'd0 : pin + 3'd1;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   assign wb.wb_ack_o          = ack;
   assign wb.wb_dat_o          = dat;
   assign charlieplex_o        = '0;
   assign charlieplex_out_en_o = (state == DRIVE) ? (7'h01 << pin) : 7'h00;
   assign irq_o                = changed & irq_en;

endmodule

// File: tb/tb_peri_charlieplex_keypad.sv
// Directed bench for peri_charlieplex_keypad with a keypad board model.
// Drives the bus on negedges and checks with immediate assertions.
module tb_peri_charlieplex_keypad;
   localparam int Frame = 7 * 16;

   logic       clk;
   logic       rst_n;
   logic [6:0] pins;
   logic [6:0] cp_o;
   logic [6:0] cp_oe;
   logic       irq;
   logic [6:0] press [7];
   logic [7:0] rd;
   int         vectors;
   int         miscompares;

   peri_charlieplex_keypad_if bus ();

   peri_charlieplex_keypad dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .wb                   (bus),
      .charlieplex_i        (pins),
      .charlieplex_o        (cp_o),
      .charlieplex_out_en_o (cp_oe),
      .irq_o                (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Board: pull-ups, driven pins follow cp_o, a closed key
   // joins its sense pin to its drive pin.
   always_comb begin
      pins = 7'h7f;
      for (int d = 0; d < 7; d++)
         for (int k = 0; k < 7; k++)
            if (press[d][k] && cp_oe[d])
               pins[k] = cp_o[d];
      for (int d = 0; d < 7; d++)
         if (cp_oe[d])
            pins[d] = cp_o[d];
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wb_rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = a;
      @(negedge clk);
      check("rd_ack", {7'b0, bus.wb_ack_o}, 8'h01);
      d = bus.wb_dat_o;
      bus.wb_stb_i = 1'b0;
   endtask

   task automatic wb_wr(input logic [3:0] a, input logic [7:0] v);
      @(negedge clk);
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b1;
      bus.wb_adr_i = a;
      bus.wb_dat_i = v;
      @(negedge clk);
      check("wr_ack", {7'b0, bus.wb_ack_o}, 8'h01);
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wait_oe(input logic [6:0] v, input string tag);
      int n;
      n = 0;
      while (cp_oe !== v && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check(tag, {1'b0, cp_oe}, {1'b0, v});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 7; i++) press[i] = '0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_oe", {1'b0, cp_oe}, 8'h00);
      check("rst_o", {1'b0, cp_o}, 8'h00);
      check("rst_irq", {7'b0, irq}, 8'h00);
      check("rst_ack", {7'b0, bus.wb_ack_o}, 8'h00);
      check("rst_dat", bus.wb_dat_o, 8'h00);
      rst_n = 1'b1;
      check("idle_oe", {1'b0, cp_oe}, 8'h00);
      for (int k = 1; k <= 128; k++) begin
         @(posedge clk);
         #1;
         check("scan_oe", {1'b0, cp_oe},
               8'h01 << (((k - 1) / 16) % 7));
      end
      wb_rd(4'd8, rd);
      check("ctrl_rst", rd, 8'h01);
      for (int r = 0; r < 7; r++) begin
         wb_rd(4'(r), rd);
         check("row_rst", rd, 8'h00);
      end

      // Single key: drive 1, sense 3
      press[1][3] = 1'b1;
      repeat (3 * Frame) @(negedge clk);
      wb_rd(4'd1, rd);
      check("row1_key", rd, 8'h08);
      wb_rd(4'd7, rd);
      check("stat_chg", rd, 8'h03);
      check("irq_off", {7'b0, irq}, 8'h00);
      press[1][3] = 1'b0;
      repeat (3 * Frame) @(negedge clk);
      wb_rd(4'd1, rd);
      check("row1_rel", rd, 8'h00);
      wb_wr(4'd7, 8'h01);
      wb_rd(4'd7, rd);
      check("stat_clr", rd, 8'h02);

      // Glitch lasting one pin-1 slot
      wait_oe(7'h01, "wait_p0");
      wait_oe(7'h02, "wait_p1");
      press[1][3] = 1'b1;
      wait_oe(7'h04, "wait_p2");
      press[1][3] = 1'b0;
      repeat (2 * Frame) @(negedge clk);
      wb_rd(4'd1, rd);
      check("glitch_row", rd, 8'h00);
      wb_rd(4'd7, rd);
      check("glitch_stat", rd, 8'h02);

      // W1C and irq: drive 2, sense 5
      wb_wr(4'd8, 8'h03);
      press[2][5] = 1'b1;
      repeat (3 * Frame) @(negedge clk);
      check("irq_press", {7'b0, irq}, 8'h01);
      wb_rd(4'd2, rd);
      check("row2_key", rd, 8'h20);
      wb_wr(4'd7, 8'h01);
      check("irq_clr", {7'b0, irq}, 8'h00);
      press[2][5] = 1'b0;
      repeat (3 * Frame) @(negedge clk);
      check("irq_rel", {7'b0, irq}, 8'h01);
      wb_rd(4'd2, rd);
      check("row2_rel", rd, 8'h00);

      // Disable mid-slot at cnt 5 of pin 4
      press[0][6] = 1'b1;
      repeat (3 * Frame) @(negedge clk);
      wb_rd(4'd0, rd);
      check("row0_key", rd, 8'h40);
      wait_oe(7'h08, "wait_p3");
      wait_oe(7'h10, "wait_p4");
      repeat (4) @(negedge clk);
      wb_wr(4'd8, 8'h00);
      @(negedge clk);
      check("dis_oe", {1'b0, cp_oe}, 8'h00);
      wb_rd(4'd7, rd);
      check("dis_stat", rd, 8'h01);
      check("dis_irq", {7'b0, irq}, 8'h00);
      press[0][6] = 1'b0;
      repeat (2 * Frame) @(negedge clk);
      wb_rd(4'd0, rd);
      check("dis_row0", rd, 8'h40);
      check("dis_oe2", {1'b0, cp_oe}, 8'h00);
      wb_wr(4'd8, 8'h01);
      check("ren_idle", {1'b0, cp_oe}, 8'h00);
      @(negedge clk);
      check("ren_p0", {1'b0, cp_oe}, 8'h01);

      // Bus protocol: stb held 4 cycles on address 12
      @(negedge clk);
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 4'd12;
      check("ack_c0", {7'b0, bus.wb_ack_o}, 8'h00);
      @(negedge clk);
      check("ack_c1", {7'b0, bus.wb_ack_o}, 8'h01);
      check("dat_a12", bus.wb_dat_o, 8'h00);
      @(negedge clk);
      check("ack_c2", {7'b0, bus.wb_ack_o}, 8'h00);
      @(negedge clk);
      check("ack_c3", {7'b0, bus.wb_ack_o}, 8'h01);
      check("dat_a12b", bus.wb_dat_o, 8'h00);
      bus.wb_stb_i = 1'b0;
      wb_wr(4'd12, 8'hff);
      wb_rd(4'd8, rd);
      check("ctrl_keep", rd, 8'h01);
      wb_wr(4'd3, 8'hff);
      wb_rd(4'd3, rd);
      check("ro_keep", rd, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/peri_charlieplex_keypad.md
# peri_charlieplex_keypad

Wishbone B4 peripheral that scans a 7-pin charlieplexed key matrix (up to 42 keys) and exposes debounced key state to the CPU. It is the input-side counterpart of the charlieplexed LED screen peripheral and reuses the same 7-pin drive/tristate scheme. It sits on the peripheral bus as one 16-byte register window and raises an optional interrupt on any debounced key change.

## Interface
- `SettleTicks`, default 16: clock cycles each drive pin is held before sampling. Legal values are 4 to 255.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `wb_we_i`  in  1  write enable.
- `wb_adr_i`  in  4  register address.
- `wb_dat_i`  in  8  write data.
- `wb_stb_i`  in  1  strobe; a request is pending while high.
- `wb_dat_o`  out  8  read data, valid while `wb_ack_o` is high.
- `wb_ack_o`  out  1  acknowledge, one cycle per access.
- `charlieplex_i`  in  7  pin levels. Pins have external pull-ups; a pressed key pulls its sense pin to the driven pin.
- `charlieplex_o`  out  7  output value. Constant 0, so any enabled pin drives low.
- `charlieplex_out_en_o`  out  7  output enable, one-hot on the current drive pin while scanning, else 0.
- `irq_o`  out  1  level interrupt, equal to `changed & irq_en`.

## Operation
- **Input synchronizer:** `charlieplex_i` passes through a 2-flop synchronizer to give `sync`. The active-high raw sample is `~sync`.
- **Scan FSM:** two states, IDLE and DRIVE.
  - IDLE: `out_en` = 0, `pin` = 0, `cnt` = 0. Moves to DRIVE when `enable` = 1.
  - DRIVE: `out_en` = `1 << pin`. `cnt` counts from 0 to `SettleTicks-1`.
  - On the cycle where `cnt == SettleTicks-1`, the block samples, sets `cnt` to 0, and sets `pin` to `(pin == 6) ? 0 : pin+1`.
  - When `enable` = 0 in DRIVE, the next state is IDLE. This abandons the current slot; no sample is taken.
- **Per-row sample:**
  - `s` = `~sync`, with bit `pin` and bit 7 forced to 0.
  - Bit j of row `pin` means key (drive `pin`, sense j) is pressed.
- **Debounce:** two consecutive agreeing scans per row.
  - Storage: `raw[7][8]` holds the previous sample; `key[7][8]` holds the debounced state.
  - On a row sample, for each bit, if `s[j] == raw[pin][j]` then `key[pin][j]` takes `s[j]`. In all cases `raw[pin]` takes `s`.
  - If any `key[pin]` bit changes, `changed` is set to 1.
- **Ghosting:** not resolved. Three or more simultaneous keys may alias, and this is documented behaviour.
- **Register map:**
  - 0–6 (RO): `key[n]`.
  - 7 STATUS: bit0 `changed`, write-1-to-clear; bit1 `scanning` (RO, 1 when in DRIVE); other bits read 0.
  - 8 CTRL (RW): bit0 `enable`, bit1 `irq_en`; other bits read 0.
  - 9–15: read 0, writes ignored.
  - Writes to read-only registers are ignored.
- **Simultaneous events:** if the write-1-to-clear of `changed` and a set happen in the same cycle, the set wins.
- **Reset** (asynchronous, any time, including mid-slot):
  - All `key`, `raw`, `changed`, `cnt`, `pin` = 0.
  - `enable` = 1, `irq_en` = 0, FSM = IDLE.
  - `wb_ack_o` = 0, `wb_dat_o` = 0, `charlieplex_out_en_o` = 0, `charlieplex_o` = 0, `irq_o` = 0.

## Timing
- **Bus access:**
  - `wb_ack_o` is registered: `ack <= wb_stb_i & ~ack`. Every access has one wait cycle, and ack is never high on two consecutive cycles.
  - `wb_dat_o` is registered in the same cycle as ack and holds the register value as of the request cycle. It is 0 when no ack is given.
  - Writes take effect on the edge that raises ack.
- **Scan rate:**
  - One slot lasts `SettleTicks` cycles; one frame is `7*SettleTicks` cycles.
  - The first DRIVE slot starts the cycle after IDLE is left; IDLE lasts one cycle after reset.
- **Sample point:** the sample uses the synchronized value, which reflects pin levels from 2 cycles earlier. `SettleTicks >= 4` guarantees the enable has propagated.
- **Latency:**
  - A held press appears in `key` at the second sample of its row: between 1 and 2 frames plus 2 cycles after the level change.
  - `changed` and `irq_o` rise on the cycle after that sample edge.

## Test plan
- **Reset:** deassert reset and let the block idle. Expect all outputs 0. Read 8 → 0x01. Read 0–6 → 0x00. After 1 cycle, `out_en` steps 0x01, 0x02, … 0x40, 0x01, each held 16 cycles.
- **Single key:** hold pin 3 low while pin 1 is driven, for 3 frames. Expect row 1 = 0x08 and `changed` = 1. Read 7 → 0x03.
- **Glitch rejection:** hold pin 3 low during one pin-1 slot only. Expect row 1 to stay 0x00 and `changed` to stay 0.
- **Write-1-to-clear and irq:**
  - Write 8 ← 0x03. Press a key; expect `irq_o` = 1.
  - Write 7 ← 0x01; expect `irq_o` = 0 next cycle.
  - Release the key; after 2 frames, expect `irq_o` = 1 again.
- **Disable mid-slot:** write 8 ← 0x00 at `cnt` = 5 of pin 4. Expect `out_en` = 0 and `scanning` = 0, with `key` unchanged. Re-enable; expect the scan to restart at pin 0.
- **Bus protocol:** hold `wb_stb_i` high for 4 cycles. Expect the ack pattern 0,1,0,1. Read address 12 → 0x00.
